fifo_rd_arbiter: RTL and testbench

Read-side port arbiter for the asynchronous FIFO. It sits in the read clock domain between the FIFO's read interface (`rd_inc`, `rd_empty`, `rd_data`) and up to `NUM_REQ` downstream consumers. It grants the single FIFO read port round-robin, pops words on behalf of the granted consumer in bounded bursts, and delivers each popped word through a registered output stage tagged with the owner's index.

---
 rtl/fifo_rd_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arbiter
// Purpose  : Read-side round-robin port arbiter for an asynchronous FIFO.
//            Grants the single FIFO read port to one of NUM_REQ consumers,
//            pops words for the grantee in bounded bursts and delivers each
//            word through a registered output stage tagged with its owner.
// Config   : FIFO_RD_ARB_BURST_EN - when defined, bursts of up to MAX_BURST
//            words per grant; when undefined, one word per grant
//            (word-interleaved round-robin) and MAX_BURST is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst,
    input  logic                       rd_empty,
    input  logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_inc,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         cons_ready,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id
);

    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(MAX_BURST + 1);

`ifdef FIFO_RD_ARB_BURST_EN
    localparam int c_burst_limit = MAX_BURST;
`else
    localparam int c_burst_limit = 1;
`endif

    localparam logic [c_cnt_w-1:0] c_burst_last = c_cnt_w'(c_burst_limit);
    localparam logic [c_id_w-1:0]  c_last_rst   = c_id_w'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_id_w-1:0]   r_owner;
    logic [c_id_w-1:0]   r_last;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_inc;
    logic [c_id_w-1:0]   w_sel;
    logic [31:0]         w_idx;
    logic                w_start;
    logic                w_exit;

    assign w_cnt_inc = r_cnt + c_cnt_w'(1);

    // Round-robin pick: first requester searching upward from last+1.
    // Scanning offsets from farthest to nearest lets the nearest win.
    always_comb begin
        w_sel = r_last;
        w_idx = 32'd0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = (32'(r_last) + 32'(i)) % 32'(NUM_REQ);
            if (req[c_id_w'(w_idx)]) begin
                w_sel = c_id_w'(w_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, pop strobe and burst exit decision.
    always_comb begin
        w_state_nxt = r_state;
        rd_inc      = 1'b0;
        w_start     = 1'b0;
        w_exit      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((|req) && !rd_empty) begin
                    w_start     = 1'b1;
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                rd_inc = !rd_empty && req[r_owner] && cons_ready[r_owner];
                // Limit reached on this pop, owner withdrew, or FIFO ran dry.
                if ((rd_inc && (w_cnt_inc == c_burst_last)) ||
                    !req[r_owner] || rd_empty) begin
                    w_exit      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant, owner, rotation pointer and burst counter.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            gnt     <= '0;
            r_owner <= '0;
            r_last  <= c_last_rst;
            r_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_owner <= w_sel;
                gnt     <= NUM_REQ'(1) << w_sel;
                r_cnt   <= '0;
            end else if (rd_inc) begin
                r_cnt   <= w_cnt_inc;
            end
            if (w_exit) begin
                r_last  <= r_owner;
                gnt     <= '0;
            end
        end
    end

    // Registered output stage: one-cycle valid pulse per popped word.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            out_valid <= rd_inc;
            if (rd_inc) begin
                out_data <= rd_data;
                out_id   <= r_owner;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_arbiter
// Purpose  : Directed, table-driven bench for fifo_rd_arbiter with a small
//            FIFO read-side model. Expectations follow the build's burst
//            limit (FIFO_RD_ARB_BURST_EN defined: 4, otherwise 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
`ifdef FIFO_RD_ARB_BURST_EN
    localparam int EFF = MAX_BURST;
`else
    localparam int EFF = 1;
`endif

    logic                  rd_clk = 1'b0;
    logic                  rd_rst = 1'b0;
    logic                  rd_empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_inc;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ-1:0]    cons_ready = '1;
    logic [NUM_REQ-1:0]    gnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_id;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .rd_empty   (rd_empty),
        .rd_data    (rd_data),
        .rd_inc     (rd_inc),
        .req        (req),
        .cons_ready (cons_ready),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    // FIFO read-side model: registered empty, combinational read data.
    logic [7:0] mem [0:63];
    logic [5:0] rptr;
    logic [5:0] wptr = 6'd0;
    wire  [5:0] rptr_nxt = rptr + ((rd_inc && !rd_empty) ? 6'd1 : 6'd0);
    assign rd_data = mem[rptr];

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rptr     <= wptr;
            rd_empty <= 1'b1;
        end else begin
            rptr     <= rptr_nxt;
            rd_empty <= (rptr_nxt == wptr);
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] rdy;
        logic [3:0] gnt;
        logic       inc;
        logic       valid;
        logic [1:0] id;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    endtask

    task automatic add(input logic [3:0] rq, input logic [3:0] rdy,
                       input logic [3:0] g, input logic inc, input logic v,
                       input logic [1:0] id, input logic [7:0] d);
        vec_t t;
        t.req = rq; t.rdy = rdy; t.gnt = g; t.inc = inc;
        t.valid = v; t.id = id; t.data = d;
        tbl.push_back(t);
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wptr] = base + 8'(i);
            wptr      = wptr + 6'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rst     = 1'b1;
        req        = '0;
        cons_ready = '1;
        @(negedge rd_clk);
        rd_rst     = 1'b0;
    endtask

    // One row per cycle: drive inputs after the falling edge, then check.
    task automatic run_table(input string tag);
        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge rd_clk);
            req        = tbl[r].req;
            cons_ready = tbl[r].rdy;
            #1;
            chk({tag, ".gnt"},       r, 32'(gnt),       32'(tbl[r].gnt));
            chk({tag, ".rd_inc"},    r, 32'(rd_inc),    32'(tbl[r].inc));
            chk({tag, ".out_valid"}, r, 32'(out_valid), 32'(tbl[r].valid));
            if (tbl[r].valid) begin
                chk({tag, ".out_id"},   r, 32'(out_id),   32'(tbl[r].id));
                chk({tag, ".out_data"}, r, 32'(out_data), 32'(tbl[r].data));
            end
        end
        tbl.delete();
    endtask

    // Expected trace for all-ready streaming: every grant pops EFF words,
    // one IDLE bubble per grant, owners rotate over the nown lowest ports.
    task automatic fill_stream(input int nwords, input logic [3:0] mask,
                               input int nown, input logic [7:0] base);
        int rows;
        rows = (nwords / EFF) * (EFF + 1) + 2;
        for (int r = 0; r < rows; r++) add(mask, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        for (int w = 0; w < nwords; w++) begin
            int b, r, own;
            b   = w / EFF;
            own = b % nown;
            r   = b * (EFF + 1) + 1 + (w % EFF);
            tbl[r].gnt       = 4'(1 << own);
            tbl[r].inc       = 1'b1;
            tbl[r + 1].valid = 1'b1;
            tbl[r + 1].id    = 2'(own);
            tbl[r + 1].data  = base + 8'(w);
        end
    endtask

    initial begin
        // Reset defaults.
        #1 rd_rst = 1'b1;
        @(negedge rd_clk); #1;
        chk("rst.gnt",       0, 32'(gnt),       32'h0);
        chk("rst.out_valid", 0, 32'(out_valid), 32'h0);
        chk("rst.rd_inc",    0, 32'(rd_inc),    32'h0);
        chk("rst.out_data",  0, 32'(out_data),  32'h0);
        chk("rst.out_id",    0, 32'(out_id),    32'h0);
        @(negedge rd_clk);
        rd_rst = 1'b0;

        // Asynchronous reset in the middle of a grant.
        load(8, 8'h00);
        @(negedge rd_clk); req = 4'hF; #1;
        chk("midrst.idle_gnt", 0, 32'(gnt), 32'h0);
        @(negedge rd_clk); #1;
        chk("midrst.gnt",    1, 32'(gnt),    32'h1);
        chk("midrst.rd_inc", 1, 32'(rd_inc), 32'h1);
        @(negedge rd_clk); #1;
        chk("midrst.valid", 2, 32'(out_valid), 32'h1);
        #2 rd_rst = 1'b1;
        #1;
        chk("midrst.gnt_clr",   3, 32'(gnt),       32'h0);
        chk("midrst.valid_clr", 3, 32'(out_valid), 32'h0);
        chk("midrst.inc_clr",   3, 32'(rd_inc),    32'h0);
        @(negedge rd_clk);
        rd_rst = 1'b0;
        load(4, 8'h20);
        @(negedge rd_clk); #1;
        chk("midrst.post_idle", 4, 32'(gnt), 32'h0);
        @(negedge rd_clk); #1;
        chk("midrst.first_gnt", 5, 32'(gnt), 32'h1);

        // Round-robin rotation over 16 words, all consumers requesting.
        do_reset();
        load(16, 8'h10);
        fill_stream(16, 4'hF, 4, 8'h10);
        run_table("rr");

        // Burst cut short by an empty FIFO.
        do_reset();
        load(2, 8'h40);
`ifdef FIFO_RD_ARB_BURST_EN
        add(4'h4, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'h4, 4'hF, 4'h4, 1, 0, 2'd0, 8'h00);
        add(4'h4, 4'hF, 4'h4, 1, 1, 2'd2, 8'h40);
        add(4'h4, 4'hF, 4'h4, 0, 1, 2'd2, 8'h41);
        add(4'h4, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
`else
        add(4'h4, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'h4, 4'hF, 4'h4, 1, 0, 2'd0, 8'h00);
        add(4'h4, 4'hF, 4'h0, 0, 1, 2'd2, 8'h40);
        add(4'h4, 4'hF, 4'h4, 1, 0, 2'd0, 8'h00);
        add(4'h4, 4'hF, 4'h0, 0, 1, 2'd2, 8'h41);
        add(4'h4, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
`endif
        run_table("empty");
        // last is now 2, so with everyone requesting consumer 3 wins.
        load(2, 8'h48);
        add(4'h0, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'hF, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'h0, 4'hF, 4'h8, 0, 0, 2'd0, 8'h00);
        add(4'h0, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
        run_table("after_empty");

        // Consumer 1 stalls for three cycles while holding its grant.
        do_reset();
        load(8, 8'h50);
`ifdef FIFO_RD_ARB_BURST_EN
        add(4'h2, 4'h2, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'h2, 4'h2, 4'h2, 1, 0, 2'd0, 8'h00);
        add(4'h2, 4'h0, 4'h2, 0, 1, 2'd1, 8'h50);
        add(4'h2, 4'h0, 4'h2, 0, 0, 2'd0, 8'h00);
        add(4'h2, 4'h0, 4'h2, 0, 0, 2'd0, 8'h00);
        add(4'h2, 4'h2, 4'h2, 1, 0, 2'd0, 8'h00);
        add(4'h2, 4'h2, 4'h2, 1, 1, 2'd1, 8'h51);
        add(4'h2, 4'h2, 4'h2, 1, 1, 2'd1, 8'h52);
        add(4'h0, 4'h2, 4'h0, 0, 1, 2'd1, 8'h53);
        add(4'h0, 4'h2, 4'h0, 0, 0, 2'd0, 8'h00);
`else
        add(4'h2, 4'h2, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'h2, 4'h2, 4'h2, 1, 0, 2'd0, 8'h00);
        add(4'h2, 4'h0, 4'h0, 0, 1, 2'd1, 8'h50);
        add(4'h2, 4'h0, 4'h2, 0, 0, 2'd0, 8'h00);
        add(4'h2, 4'h0, 4'h2, 0, 0, 2'd0, 8'h00);
        add(4'h2, 4'h0, 4'h2, 0, 0, 2'd0, 8'h00);
        add(4'h2, 4'h2, 4'h2, 1, 0, 2'd0, 8'h00);
        add(4'h0, 4'h2, 4'h0, 0, 1, 2'd1, 8'h51);
        add(4'h0, 4'h2, 4'h0, 0, 0, 2'd0, 8'h00);
`endif
        run_table("stall");

        // Owner 0 withdraws after one word; consumer 3 is waiting.
        do_reset();
        load(8, 8'h60);
`ifdef FIFO_RD_ARB_BURST_EN
        add(4'h9, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'h9, 4'hF, 4'h1, 1, 0, 2'd0, 8'h00);
        add(4'h8, 4'hF, 4'h1, 0, 1, 2'd0, 8'h60);
        add(4'h8, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'h8, 4'hF, 4'h8, 1, 0, 2'd0, 8'h00);
        add(4'h0, 4'hF, 4'h8, 0, 1, 2'd3, 8'h61);
        add(4'h0, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
`else
        add(4'h9, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
        add(4'h9, 4'hF, 4'h1, 1, 0, 2'd0, 8'h00);
        add(4'h8, 4'hF, 4'h0, 0, 1, 2'd0, 8'h60);
        add(4'h8, 4'hF, 4'h8, 1, 0, 2'd0, 8'h00);
        add(4'h0, 4'hF, 4'h0, 0, 1, 2'd3, 8'h61);
        add(4'h0, 4'hF, 4'h0, 0, 0, 2'd0, 8'h00);
`endif
        run_table("withdraw");

        // Two consumers sharing 8 words.
        do_reset();
        load(8, 8'h80);
        fill_stream(8, 4'h3, 2, 8'h80);
        run_table("pair");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
